// File: rtl/audio_tone_gen.sv
// audio_tone_gen
//   Square-wave tone generator driven by the processor's audio port levels.
//   The note select picks a half-period, the volume scales the output, and a
//   rising edge on the enable starts a note. The tone is produced both as a
//   1-bit PWM speaker drive and as a 5-bit amplitude for an external DAC.
//
//   Optional feature macro: AUDIO_ENV_EN
//     Defined   -> linear decay envelope: every DECAY_TICKS tone ticks the
//                  current volume drops by one; reaching 0 ends the note.
//     Undefined -> the volume simply follows the registered audioVol input.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   audioVol     requested volume 0..31
//   audioSel     note select, 0 = rest, 1..15 = tones (higher = shorter period)
//   audioEn      level enable; a rising edge starts a note, low stops it
//   audio_pwm    PWM speaker drive, high for cur_vol of every 31 clk while sq=1
//   audio_level  cur_vol while the square wave is high, else 0
//   note_active  high while a tone with non-zero select and volume is sounding
//
// Interface: plain level inputs, no handshake. Every input is registered once
// and only the registered copies feed decisions, so inputs have one cycle of
// latency. Outputs audio_pwm / audio_level are registered and always equal the
// combination of the current sq, pwm_cnt and cur_vol registers.
//
// The FSM state is the internal signal `state` (IDLE / PLAY).

module audio_tone_gen #(
  parameter int PRESCALE    = 50,
  parameter int BASE_HP     = 64,
  parameter int HP_STEP     = 8,
  parameter int DECAY_TICKS = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] audioVol,
  input  logic [3:0] audioSel,
  input  logic       audioEn,
  output logic       audio_pwm,
  output logic [4:0] audio_level,
  output logic       note_active
);

  // Longest half-period is for select 1; size the phase counter for it.
  localparam int HP_MAX = BASE_HP + HP_STEP * 14;
  localparam int HP_W   = $clog2(HP_MAX + 1);
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // An illegal parameter set elaborates this named empty block, which makes
  // the mistake visible in the elaborated hierarchy.
  if (PRESCALE < 1 || DECAY_TICKS < 1) begin : g_bad_params
  end

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state, state_next;

  // Registered inputs
  logic             en_q, en_prev;
  logic [3:0]       sel_q;
  logic [4:0]       vol_q;

  // Note state
  logic [3:0]       cur_sel, cur_sel_next;
  logic [4:0]       cur_vol, cur_vol_next;
  logic [PRE_W-1:0] pre_cnt, pre_next;
  logic [HP_W-1:0]  ph_cnt, ph_next, hp_m1;
  logic             sq, sq_next;
  logic [4:0]       pwm_cnt, pwm_next;

  logic             tick;
  logic             start;
  logic             stop;

`ifdef AUDIO_ENV_EN
  localparam int DEC_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  logic [4:0]       vol_prev;
  logic [DEC_W-1:0] dec_cnt, dec_next;
`endif

  // Input capture. These registers carry no reset: they keep sampling while
  // reset is held, so an enable level held across reset is seen as steady
  // (no rising edge) and cannot start a note on release.
  always_ff @(posedge clk) begin
    en_q    <= audioEn;
    en_prev <= en_q;
    sel_q   <= audioSel;
    vol_q   <= audioVol;
`ifdef AUDIO_ENV_EN
    vol_prev <= vol_q;
`endif
  end

  // Half-period minus one for the current select. Only meaningful for
  // selects 1..15; a rest (select 0) never advances the phase.
  always_comb begin
    hp_m1 = HP_W'(BASE_HP - 1 + HP_STEP * (15 - int'(cur_sel)));
  end

  assign tick = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Next-state and datapath logic
  always_comb begin
    state_next   = state;
    cur_sel_next = cur_sel;
    cur_vol_next = cur_vol;
    pre_next     = pre_cnt;
    ph_next      = ph_cnt;
    sq_next      = sq;
    pwm_next     = pwm_cnt;
`ifdef AUDIO_ENV_EN
    dec_next     = dec_cnt;
`endif
    start        = 1'b0;
    stop         = 1'b0;

    case (state)
      IDLE: begin
        if (en_q && !en_prev) begin
          start = 1'b1;
        end
      end

      PLAY: begin
        pre_next = tick ? '0 : pre_cnt + PRE_W'(1);
        pwm_next = (pwm_cnt == 5'd30) ? 5'd0 : pwm_cnt + 5'd1;

        // Priority: enable fall, then retune, then phase/volume updates.
        if (!en_q) begin
          stop = 1'b1;
        end else if (sel_q != cur_sel) begin
          start = 1'b1;
        end else begin
          if (cur_sel == 4'd0) begin
            sq_next = 1'b0;
            ph_next = '0;
          end else if (tick) begin
            if (ph_cnt == hp_m1) begin
              ph_next = '0;
              sq_next = ~sq;
            end else begin
              ph_next = ph_cnt + HP_W'(1);
            end
          end

`ifdef AUDIO_ENV_EN
          // A fresh volume request reloads the envelope; otherwise decay.
          if (vol_q != vol_prev) begin
            cur_vol_next = vol_q;
            dec_next     = '0;
          end else if (tick && cur_vol != 5'd0) begin
            if (dec_cnt == DEC_W'(DECAY_TICKS - 1)) begin
              dec_next     = '0;
              cur_vol_next = cur_vol - 5'd1;
              if (cur_vol == 5'd1) begin
                stop = 1'b1;
              end
            end else begin
              dec_next = dec_cnt + DEC_W'(1);
            end
          end
`else
          cur_vol_next = vol_q;
`endif
        end
      end

      default: begin
        stop = 1'b1;
      end
    endcase

    // Leaving PLAY discards the in-flight phase so outputs drop immediately.
    if (stop) begin
      state_next   = IDLE;
      cur_sel_next = '0;
      cur_vol_next = '0;
      pre_next     = '0;
      ph_next      = '0;
      sq_next      = 1'b0;
      pwm_next     = '0;
`ifdef AUDIO_ENV_EN
      dec_next     = '0;
`endif
    end

    // Note entry and retune share one path. The PWM counter is left alone so
    // a retune does not disturb the duty cycle; from IDLE it is already 0.
    if (start) begin
      state_next   = PLAY;
      cur_sel_next = sel_q;
      cur_vol_next = vol_q;
      pre_next     = '0;
      ph_next      = '0;
      sq_next      = (sel_q != 4'd0);
`ifdef AUDIO_ENV_EN
      dec_next     = '0;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur_sel     <= '0;
      cur_vol     <= '0;
      pre_cnt     <= '0;
      ph_cnt      <= '0;
      sq          <= 1'b0;
      pwm_cnt     <= '0;
      audio_pwm   <= 1'b0;
      audio_level <= '0;
`ifdef AUDIO_ENV_EN
      dec_cnt     <= '0;
`endif
    end else begin
      state       <= state_next;
      cur_sel     <= cur_sel_next;
      cur_vol     <= cur_vol_next;
      pre_cnt     <= pre_next;
      ph_cnt      <= ph_next;
      sq          <= sq_next;
      pwm_cnt     <= pwm_next;
      // Computed from the next-state values so the registered outputs line
      // up with sq / pwm_cnt / cur_vol in the same cycle.
      audio_pwm   <= sq_next & (pwm_next < cur_vol_next);
      audio_level <= sq_next ? cur_vol_next : 5'd0;
`ifdef AUDIO_ENV_EN
      dec_cnt     <= dec_next;
`endif
    end
  end

  assign note_active = (state == PLAY) && (cur_sel != 4'd0) && (cur_vol != 5'd0);

endmodule
